// File: rtl/sram_dual_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_dual_port_arbiter
// Brief    : Round-robin sharing of one single-port synchronous SRAM macro
//            between two valid/ready requesters, with optional zero-clear
//            of the whole array after reset.
// Revision : 1.0  initial release
// ============================================================================
module sram_dual_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 2,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    // requester 0
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    // requester 1
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    // SRAM macro pins
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    // status
    output logic                  init_done,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_INIT_CMD = 3'd0,
        ST_INIT_REL = 3'd1,
        ST_IDLE     = 3'd2,
        ST_CMD      = 3'd3,
        ST_WAIT     = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_CNT_LAST = {ADDR_WIDTH{1'b1}};

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_init_done;
    logic                    r_last_grant;
    logic                    r_id;
    logic                    r_we;
    logic                    r_csb;
    logic                    r_web;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_din;
    logic                    r_rsp0_valid;
    logic                    r_rsp1_valid;
    logic [DATA_WIDTH-1:0]   r_rsp0_rdata;
    logic [DATA_WIDTH-1:0]   r_rsp1_rdata;

    logic                    w_can_accept;
    logic                    w_accept;
    logic                    w_grant;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    // Round-robin pick: on a tie the side not granted last time wins,
    // otherwise whichever side is valid (req0 when neither is).
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Ready is withheld while reset is held so the idle-state bypass
    // (INIT_CLEAR=0) never shows ready before reset is released.
    assign w_can_accept = (r_state == ST_IDLE) && r_init_done && !rst0;
    assign w_accept     = w_can_accept && (req0_valid || req1_valid);
    assign req0_ready   = w_can_accept && req0_valid && !w_grant;
    assign req1_ready   = w_can_accept && req1_valid &&  w_grant;

    assign w_sel_we    = w_grant ? req1_we    : req0_we;
    assign w_sel_addr  = w_grant ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant ? req1_wdata : req0_wdata;

    // Main sequencer: clear walk, command issue, read capture and response.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            r_state      <= (INIT_CLEAR != 0) ? ST_INIT_CMD : ST_IDLE;
            r_init_done  <= (INIT_CLEAR == 0);
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_csb        <= 1'b1;
            r_web        <= 1'b1;
            r_addr       <= '0;
            r_din        <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            case (r_state)
                ST_INIT_CMD: begin
                    r_csb   <= 1'b0;
                    r_web   <= 1'b0;
                    r_addr  <= r_cnt;
                    r_din   <= '0;
                    r_state <= ST_INIT_REL;
                end
                ST_INIT_REL: begin
                    r_csb  <= 1'b1;
                    r_web  <= 1'b1;
                    r_addr <= '0;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_init_done <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_INIT_CMD;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_csb        <= 1'b0;
                        r_web        <= ~w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_din        <= w_sel_we ? w_sel_wdata : '0;
                        r_id         <= w_grant;
                        r_we         <= w_sel_we;
                        r_last_grant <= w_grant;
                        r_state      <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // Macro samples the command on this edge; release pins.
                    r_csb   <= 1'b1;
                    r_web   <= 1'b1;
                    r_addr  <= '0;
                    r_din   <= '0;
                    r_state <= r_we ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_id) begin
                        r_rsp1_rdata <= dout0;
                        r_rsp1_valid <= 1'b1;
                    end else begin
                        r_rsp0_rdata <= dout0;
                        r_rsp0_valid <= 1'b1;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_csb   <= 1'b1;
                    r_web   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign csb0       = r_csb;
    assign web0       = r_web;
    assign addr0      = r_addr;
    assign din0       = r_din;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_rdata = r_rsp1_rdata;
    assign init_done  = r_init_done;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_dual_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_dual_port_arbiter
// Brief    : Scoreboard bench for sram_dual_port_arbiter with a behavioural
//            model of the single-port SRAM macro.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_dual_port_arbiter;

    logic       clk0 = 1'b0;
    logic       rst0;
    logic       req0_valid, req0_we, req1_valid, req1_we;
    logic [3:0] req0_addr, req1_addr;
    logic [1:0] req0_wdata, req1_wdata;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [1:0] rsp0_rdata, rsp1_rdata;
    logic       csb0, web0, init_done, busy;
    logic [3:0] addr0;
    logic [1:0] din0, dout0;

    // second instance, no clear sequence
    logic       rst_nc, nc_req0_valid, nc_req0_ready, nc_req1_ready;
    logic       nc_rsp0_valid, nc_rsp1_valid, nc_csb0, nc_web0;
    logic       nc_init_done, nc_busy;
    logic [1:0] nc_rsp0_rdata, nc_rsp1_rdata, nc_din0;
    logic [3:0] nc_addr0;
    logic [1:0] nc_dout0 = 2'b00;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0] d;
        int         t;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         glog[$];
    logic [1:0] exp_mem [16];
    logic [1:0] mem     [16];

    always #5 clk0 = ~clk0;
    always @(posedge clk0) cyc <= cyc + 1;

    sram_dual_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(2), .INIT_CLEAR(1)) u_dut (
        .clk0(clk0), .rst0(rst0),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .init_done(init_done), .busy(busy)
    );

    sram_dual_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(2), .INIT_CLEAR(0)) u_dut_nc (
        .clk0(clk0), .rst0(rst_nc),
        .req0_valid(nc_req0_valid), .req0_ready(nc_req0_ready), .req0_we(1'b0),
        .req0_addr(4'd0), .req0_wdata(2'd0),
        .rsp0_valid(nc_rsp0_valid), .rsp0_rdata(nc_rsp0_rdata),
        .req1_valid(1'b0), .req1_ready(nc_req1_ready), .req1_we(1'b0),
        .req1_addr(4'd0), .req1_wdata(2'd0),
        .rsp1_valid(nc_rsp1_valid), .rsp1_rdata(nc_rsp1_rdata),
        .csb0(nc_csb0), .web0(nc_web0), .addr0(nc_addr0), .din0(nc_din0), .dout0(nc_dout0),
        .init_done(nc_init_done), .busy(nc_busy)
    );

    // SRAM macro model: pins latched on rising edge, array access on falling edge.
    logic       m_csb = 1'b1, m_web = 1'b1;
    logic [3:0] m_addr = '0;
    logic [1:0] m_din = '0;
    initial begin
        dout0 = 2'b00;
        for (int i = 0; i < 16; i++) mem[i] = 2'((i % 3) + 1);
    end
    always @(posedge clk0) begin
        m_csb  <= csb0;
        m_web  <= web0;
        m_addr <= addr0;
        m_din  <= din0;
    end
    always @(negedge clk0) begin
        if (!m_csb) begin
            if (!m_web) mem[m_addr] <= m_din;
            else        dout0 <= mem[m_addr];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Response monitor: pops the expectation of the port that pulsed.
    always @(negedge clk0) begin
        exp_t e;
        if (rsp0_valid) begin
            if (q0.size() == 0) check("rsp0_unexpected", 1, 0);
            else begin
                e = q0.pop_front();
                check("rsp0_rdata", rsp0_rdata, e.d);
                check("rsp0_latency", cyc - e.t, 3);
            end
        end
        if (rsp1_valid) begin
            if (q1.size() == 0) check("rsp1_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                check("rsp1_rdata", rsp1_rdata, e.d);
                check("rsp1_latency", cyc - e.t, 3);
            end
        end
    end

    // Grant log: which port handed over a command each cycle.
    always @(negedge clk0) begin
        #2;
        if (req0_ready && req1_ready) check("dual_ready", 1, 0);
        if (req0_valid && req0_ready) glog.push_back(0);
        if (req1_valid && req1_ready) glog.push_back(1);
    end

    task automatic issue(input int p, input logic we, input logic [3:0] a,
                         input logic [1:0] d, input bit push);
        int   n;
        logic rdy;
        exp_t e;
        @(negedge clk0);
        if (p == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
        end
        n = 0;
        forever begin
            #1;
            rdy = (p == 0) ? req0_ready : req1_ready;
            if (rdy) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", p, -1);
                if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
                return;
            end
            @(negedge clk0);
        end
        if (we) exp_mem[a] = d;
        else if (push) begin
            e.d = exp_mem[a];
            e.t = cyc;
            if (p == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk0);
        #1;
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk0);
            n++;
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clk0);
            n++;
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        repeat (2) @(negedge clk0);
    endtask

    logic [3:0] wa [10] = '{4'd3, 4'd6, 4'd8, 4'd2, 4'd5, 4'd12, 4'd15, 4'd11, 4'd14, 4'd10};
    logic [1:0] wd [10] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd3,  2'd3,  2'd3,  2'd2,  2'd3};
    logic [3:0] za [4]  = '{4'd4, 4'd1, 4'd9, 4'd7};

    initial begin
        int n;
        rst0 = 1'b1; rst_nc = 1'b1; nc_req0_valid = 1'b1;
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 2'd0;
        repeat (3) @(negedge clk0);

        // reset values
        check("rst_csb0", csb0, 1);
        check("rst_web0", web0, 1);
        check("rst_addr0", addr0, 0);
        check("rst_din0", din0, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}, 0);
        check("rst_init_done", init_done, 0);
        check("nc_rst_ready", nc_req0_ready, 0);

        // T1 / T6: release both resets together
        rst0 = 1'b0; rst_nc = 1'b0;
        #1;
        check("nc_init_done", nc_init_done, 1);
        check("nc_ready_first", nc_req0_ready, 1);
        check("busy_in_init", busy, 1);
        @(posedge clk0); #1; nc_req0_valid = 1'b0;
        n = 1;
        while (!init_done && n < 100) begin
            @(posedge clk0);
            n++;
            #1;
        end
        check("init_cycles", n, 32);
        check("busy_after_init", busy, 0);
        issue(0, 1'b0, 4'd0, 2'd0, 1'b1);
        drain();

        // T2: writes then read-back and never-written reads
        for (int i = 0; i < 10; i++) issue(0, 1'b1, wa[i], wd[i], 1'b0);
        for (int i = 0; i < 10; i++) issue(0, 1'b0, wa[i], 2'd0, 1'b1);
        for (int i = 0; i < 4;  i++) issue(0, 1'b0, za[i], 2'd0, 1'b1);
        drain();
        check("t2_mem3", exp_mem[3], 1);

        // T4: write on port 1 followed by read on port 0
        issue(1, 1'b1, 4'd6, 2'd2, 1'b0);
        issue(0, 1'b0, 4'd6, 2'd0, 1'b1);
        issue(1, 1'b0, 4'd6, 2'd0, 1'b1);
        drain();

        // T3: both ports contending; port 1 was granted last
        glog.delete();
        fork
            begin issue(0, 1'b0, 4'd3, 2'd0, 1'b1); issue(0, 1'b0, 4'd8, 2'd0, 1'b1); end
            begin issue(1, 1'b0, 4'd5, 2'd0, 1'b1); issue(1, 1'b0, 4'd12, 2'd0, 1'b1); end
        join
        drain();
        check("t3_grants", glog.size(), 4);
        if (glog.size() == 4) begin
            check("t3_g0", glog[0], 0);
            check("t3_g1", glog[1], 1);
            check("t3_g2", glog[2], 0);
            check("t3_g3", glog[3], 1);
        end

        // T5: reset while a read is in WAIT; its response must be dropped
        issue(0, 1'b0, 4'd3, 2'd0, 1'b0);
        @(posedge clk0); #1;
        rst0 = 1'b1;
        #1;
        check("t5_csb0", csb0, 1);
        check("t5_init_done", init_done, 0);
        repeat (3) @(negedge clk0);
        rst0 = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 2'd0;
        wait_init(n);
        check("t5_init_cycles", n, 32);
        issue(0, 1'b0, 4'd3, 2'd0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
